// File: rtl/usb_hub_repeater.sv
// usb_hub_repeater: host/device packet repeater for the USB hub.
// Tracks connect/enable per downstream port, broadcasts host packets,
// arbitrates one upstream talker, and forces EOP on babble or loss.
// Ports: hi_clock, reset (sync, active-high); host_line_in/out, host_oe;
// dev_line_in/out (2 bits per port), dev_oe; port_enable_req,
// port_disable_req, port_status_clr pulses; port_connected,
// port_enabled, port_babble status; active_port, rpt_state debug.
module usb_hub_repeater #(
  parameter int NUM_USB_DEVICES = 2,
  parameter int CONNECT_DEBOUNCE = 16,
  parameter int MAX_PKT_CYCLES = 1500,
  localparam int N = NUM_USB_DEVICES,
  localparam int PW = ($clog2(N) > 1) ? $clog2(N) : 1
) (
  input  logic           hi_clock,
  input  logic           reset,
  input  logic [1:0]     host_line_in,
  output logic [1:0]     host_line_out,
  output logic           host_oe,
  input  logic [2*N-1:0] dev_line_in,
  output logic [2*N-1:0] dev_line_out,
  output logic [N-1:0]   dev_oe,
  input  logic [N-1:0]   port_enable_req,
  input  logic [N-1:0]   port_disable_req,
  input  logic [N-1:0]   port_status_clr,
  output logic [N-1:0]   port_connected,
  output logic [N-1:0]   port_enabled,
  output logic [N-1:0]   port_babble,
  output logic [PW-1:0]  active_port,
  output logic [2:0]     rpt_state
);

  localparam logic [1:0] LJ = 2'b10;
  localparam logic [1:0] LK = 2'b01;
  localparam logic [1:0] LSE0 = 2'b00;
  localparam int DW = $clog2(CONNECT_DEBOUNCE + 1);
  localparam int CW = $clog2(MAX_PKT_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    DOWN = 3'd1,
    UP   = 3'd2,
    FEOP = 3'd3
  } state_t;

  state_t         state;
  logic [N-1:0]   fwd_mask;
  logic           seen_se0;
  logic [CW-1:0]  pkt_cnt;
  logic [1:0]     feop_cnt;
  logic [DW-1:0]  db_cnt [N];
  logic [1:0]     db_last [N];

  logic [1:0]     dev_s [N];
  logic [DW-1:0]  cnt_nxt [N];
  logic [N-1:0]   hit_j;
  logic [N-1:0]   hit_se0;
  logic [N-1:0]   conn_nxt;
  logic [N-1:0]   en_base;
  logic [N-1:0]   en_nxt;
  logic [N-1:0]   bab_nxt;
  logic [N-1:0]   act_oh;
  logic           req_any;
  logic [PW-1:0]  req_idx;
  logic [1:0]     act_raw;
  logic [CW-1:0]  pkt_inc;
  logic           babble_hit;
  logic           lost;
  logic           h_k;
  logic           h_j;
  logic           h_se0;
  logic           a_j;
  logic           a_se0;

  function automatic logic [2*N-1:0] bcast(
    input logic [N-1:0] m,
    input logic [1:0]   l
  );
    logic [2*N-1:0] r;
    for (int k = 0; k < N; k++)
      r[2*k +: 2] = m[k] ? l : LJ;
    return r;
  endfunction

  // SE1 is folded into SE0 for all line-state decisions
  always_comb begin
    for (int k = 0; k < N; k++) begin
      dev_s[k] = dev_line_in[2*k +: 2];
      if (dev_s[k] == 2'b11)
        dev_s[k] = LSE0;
    end
  end

  always_comb begin
    for (int k = 0; k < N; k++) begin
      if (dev_s[k] == LK)
        cnt_nxt[k] = '0;
      else if (dev_s[k] != db_last[k])
        cnt_nxt[k] = DW'(1);
      else if (db_cnt[k] == DW'(CONNECT_DEBOUNCE))
        cnt_nxt[k] = db_cnt[k];
      else
        cnt_nxt[k] = db_cnt[k] + DW'(1);
      hit_j[k] = (dev_s[k] == LJ) &&
        (cnt_nxt[k] == DW'(CONNECT_DEBOUNCE));
      hit_se0[k] = (dev_s[k] == LSE0) &&
        (cnt_nxt[k] == DW'(CONNECT_DEBOUNCE));
    end
  end

  // disconnect overrides any enable in the same cycle
  always_comb begin
    conn_nxt = port_connected;
    en_base = port_enabled;
    for (int k = 0; k < N; k++) begin
      if (port_disable_req[k])
        en_base[k] = 1'b0;
      else if (port_enable_req[k] && port_connected[k])
        en_base[k] = 1'b1;
      if (hit_j[k])
        conn_nxt[k] = 1'b1;
      if (hit_se0[k]) begin
        conn_nxt[k] = 1'b0;
        en_base[k] = 1'b0;
      end
    end
  end

  // descending scan so the lowest index wins
  always_comb begin
    req_any = 1'b0;
    req_idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (port_enabled[k] && dev_s[k] == LK) begin
        req_any = 1'b1;
        req_idx = PW'(k);
      end
    end
  end

  always_comb begin
    act_oh = N'(1) << active_port;
    act_raw = dev_line_in[{active_port, 1'b0} +: 2];
    a_j = (act_raw == LJ);
    a_se0 = (act_raw[1] == act_raw[0]);
    h_k = (host_line_in == LK);
    h_j = (host_line_in == LJ);
    h_se0 = (host_line_in[1] == host_line_in[0]);
    pkt_inc = pkt_cnt + CW'(1);
    babble_hit = (state == UP) &&
      (pkt_inc == CW'(MAX_PKT_CYCLES));
    lost = (state == UP) && !en_base[active_port];
    en_nxt = en_base & ~(babble_hit ? act_oh : '0);
    bab_nxt = (port_babble & ~port_status_clr) |
      (babble_hit ? act_oh : '0);
  end

  always_ff @(posedge hi_clock) begin
    if (reset) begin
      state <= IDLE;
      fwd_mask <= '0;
      seen_se0 <= 1'b0;
      pkt_cnt <= '0;
      feop_cnt <= '0;
      active_port <= '0;
      host_line_out <= LJ;
      host_oe <= 1'b0;
      dev_line_out <= {N{LJ}};
      dev_oe <= '0;
      port_connected <= '0;
      port_enabled <= '0;
      port_babble <= '0;
      for (int k = 0; k < N; k++) begin
        db_cnt[k] <= '0;
        db_last[k] <= LK;
      end
    end else begin
      port_connected <= conn_nxt;
      port_enabled <= en_nxt;
      port_babble <= bab_nxt;
      for (int k = 0; k < N; k++) begin
        db_cnt[k] <= cnt_nxt[k];
        db_last[k] <= dev_s[k];
      end
      unique case (state)
        IDLE: begin
          host_oe <= 1'b0;
          host_line_out <= LJ;
          dev_oe <= '0;
          dev_line_out <= {N{LJ}};
          if (h_k) begin
            state <= DOWN;
            fwd_mask <= port_enabled;
            dev_oe <= port_enabled;
            dev_line_out <= bcast(port_enabled, host_line_in);
            seen_se0 <= 1'b0;
          end else if (req_any) begin
            state <= UP;
            active_port <= req_idx;
            host_oe <= 1'b1;
            host_line_out <= LK;
            pkt_cnt <= '0;
            seen_se0 <= 1'b0;
          end
        end
        DOWN: begin
          dev_oe <= fwd_mask;
          dev_line_out <= bcast(fwd_mask, host_line_in);
          if (h_se0)
            seen_se0 <= 1'b1;
          else if (h_j && seen_se0)
            state <= IDLE;
        end
        UP: begin
          host_oe <= 1'b1;
          host_line_out <= act_raw;
          pkt_cnt <= pkt_inc;
          if (babble_hit || lost) begin
            state <= FEOP;
            host_line_out <= LSE0;
            feop_cnt <= '0;
          end else if (a_se0)
            seen_se0 <= 1'b1;
          else if (a_j && seen_se0)
            state <= IDLE;
        end
        FEOP: begin
          host_oe <= 1'b1;
          feop_cnt <= feop_cnt + 2'd1;
          unique case (feop_cnt)
            2'd0: host_line_out <= LSE0;
            2'd1: host_line_out <= LJ;
            default: begin
              state <= IDLE;
              host_oe <= 1'b0;
              host_line_out <= LJ;
            end
          endcase
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rpt_state = state;

endmodule

// File: tb/tb_usb_hub_repeater.sv
// tb_usb_hub_repeater: directed steps with random packet bodies,
// expected streams held in queues and flag values from line rules.
module tb_usb_hub_repeater;

  localparam logic [1:0] J = 2'b10;
  localparam logic [1:0] K = 2'b01;
  localparam logic [1:0] SE0 = 2'b00;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] host_in;
  logic [1:0] host_out;
  logic       host_oe;
  logic [1:0] d0;
  logic [1:0] d1;
  logic [3:0] dev_in;
  logic [3:0] dev_out;
  logic [1:0] dev_oe;
  logic [1:0] en_req;
  logic [1:0] dis_req;
  logic [1:0] clr_req;
  logic [1:0] conn;
  logic [1:0] en;
  logic [1:0] bab;
  logic       act;
  logic [2:0] st;

  int total = 0;
  int passed = 0;
  int fails = 0;
  logic [1:0] seq[$];
  logic [1:0] s;
  int n;

  assign dev_in = {d1, d0};

  usb_hub_repeater #(
    .NUM_USB_DEVICES(2),
    .CONNECT_DEBOUNCE(16),
    .MAX_PKT_CYCLES(20)
  ) dut (
    .hi_clock(clk),
    .reset(reset),
    .host_line_in(host_in),
    .host_line_out(host_out),
    .host_oe(host_oe),
    .dev_line_in(dev_in),
    .dev_line_out(dev_out),
    .dev_oe(dev_oe),
    .port_enable_req(en_req),
    .port_disable_req(dis_req),
    .port_status_clr(clr_req),
    .port_connected(conn),
    .port_enabled(en),
    .port_babble(bab),
    .active_port(act),
    .rpt_state(st)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    total++;
    assert (got === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] kj();
    return ($urandom_range(0, 1) == 1) ? K : J;
  endfunction

  task automatic mk_pkt(input int body);
    seq.delete();
    seq.push_back(K);
    repeat (body) seq.push_back(kj());
    seq.push_back(SE0);
    seq.push_back(SE0);
    seq.push_back(J);
  endtask

  initial begin
    reset = 1'b1;
    host_in = J;
    d0 = SE0;
    d1 = SE0;
    en_req = '0;
    dis_req = '0;
    clr_req = '0;
    tick();
    tick();
    chk("rst_hout", host_out, J);
    chk("rst_dout", dev_out, 4'b1010);
    chk("rst_hoe", host_oe, 0);
    chk("rst_doe", dev_oe, 0);
    chk("rst_conn", conn, 0);
    chk("rst_en", en, 0);
    chk("rst_bab", bab, 0);
    chk("rst_state", st, 0);
    chk("rst_act", act, 0);
    reset = 1'b0;

    // port 1 connect: J counted from its first sample
    d1 = J;
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (i == 15) chk("conn_early", conn, 2'b00);
      if (i == 16) chk("conn_p1", conn, 2'b10);
    end
    en_req = 2'b01;
    tick();
    en_req = '0;
    chk("en_unconn", en, 2'b00);
    en_req = 2'b10;
    tick();
    en_req = '0;
    chk("en_p1", en, 2'b10);

    d0 = J;
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (i == 15) chk("conn0_early", conn, 2'b10);
      if (i == 16) chk("conn_both", conn, 2'b11);
    end
    en_req = 2'b01;
    tick();
    en_req = '0;
    chk("en_both", en, 2'b11);

    // downstream broadcast, fixed then random bodies
    for (int p = 0; p < 3; p++) begin
      if (p == 0) begin
        seq.delete();
        seq = '{K, J, K, K, SE0, SE0, J};
      end else
        mk_pkt($urandom_range(1, 6));
      for (int i = 0; i < seq.size(); i++) begin
        host_in = seq[i];
        if (p == 1 && i == 2) dis_req = 2'b01;
        tick();
        dis_req = '0;
        chk("dn_line", dev_out, {seq[i], seq[i]});
        chk("dn_oe", dev_oe, 2'b11);
        chk("dn_hoe", host_oe, 0);
        chk("dn_state", st, (i == seq.size() - 1) ? 0 : 1);
        if (p == 1 && i == 2) chk("dn_en_live", en, 2'b10);
      end
      host_in = J;
      tick();
      chk("dn_oe_off", dev_oe, 0);
      chk("dn_idle", st, 0);
      chk("dn_line_j", dev_out, 4'b1010);
      if (p == 1) begin
        en_req = 2'b01;
        tick();
        en_req = '0;
        chk("re_en", en, 2'b11);
      end
    end

    // upstream arbitration: both K, port 0 wins
    mk_pkt($urandom_range(1, 8));
    for (int i = 0; i < seq.size(); i++) begin
      d0 = seq[i];
      d1 = (i == 0) ? K : kj();
      tick();
      chk("up_line", host_out, seq[i]);
      chk("up_oe", host_oe, 1);
      chk("up_doe", dev_oe, 0);
      chk("up_state", st, (i == seq.size() - 1) ? 0 : 2);
      if (i == 0) chk("up_act", act, 0);
    end
    d0 = J;
    d1 = J;
    tick();
    chk("up_oe_off", host_oe, 0);
    chk("up_idle", st, 0);

    // host and device K together: host wins
    host_in = K;
    d1 = K;
    tick();
    chk("col_state", st, 1);
    chk("col_hoe", host_oe, 0);
    chk("col_doe", dev_oe, 2'b11);
    host_in = SE0;
    d1 = J;
    tick();
    chk("col_hoe2", host_oe, 0);
    host_in = J;
    tick();
    tick();
    chk("col_idle", st, 0);
    chk("col_doe_off", dev_oe, 0);

    // babble on port 0
    d0 = K;
    tick();
    chk("bab_up", st, 2);
    chk("bab_act", act, 0);
    for (int i = 1; i <= 19; i++) begin
      s = kj();
      d0 = s;
      tick();
      chk("bab_line", host_out, s);
      chk("bab_st", st, 2);
    end
    d0 = kj();
    tick();
    chk("bab_feop", st, 3);
    chk("bab_se0a", host_out, SE0);
    chk("bab_flag", bab, 2'b01);
    chk("bab_en", en, 2'b10);
    d0 = kj();
    tick();
    chk("bab_se0b", host_out, SE0);
    chk("bab_oe", host_oe, 1);
    tick();
    chk("bab_j", host_out, J);
    chk("bab_oe2", host_oe, 1);
    chk("bab_st3", st, 3);
    d0 = J;
    tick();
    chk("bab_idle", st, 0);
    chk("bab_oe_off", host_oe, 0);
    chk("bab_sticky", bab, 2'b01);
    clr_req = 2'b01;
    tick();
    clr_req = '0;
    chk("bab_clr", bab, 2'b00);

    // active port 1 disconnects mid-packet
    d1 = K;
    tick();
    chk("dc_up", st, 2);
    chk("dc_act", act, 1);
    chk("dc_k", host_out, K);
    n = 0;
    for (int i = 1; i <= 16; i++) begin
      d1 = SE0;
      tick();
      if (i < 16) begin
        if (st !== 3'd2 || host_out !== SE0) n++;
      end
    end
    chk("dc_fwd_errs", n, 0);
    chk("dc_feop", st, 3);
    chk("dc_conn", conn, 2'b01);
    chk("dc_en", en, 2'b00);
    chk("dc_bab", bab, 2'b00);
    chk("dc_se0", host_out, SE0);
    tick();
    chk("dc_se0b", host_out, SE0);
    tick();
    chk("dc_j", host_out, J);
    tick();
    chk("dc_idle", st, 0);
    chk("dc_oe_off", host_oe, 0);

    // reset in the middle of a downstream packet
    en_req = 2'b01;
    tick();
    en_req = '0;
    chk("rs_en", en, 2'b01);
    host_in = K;
    tick();
    chk("rs_down", st, 1);
    chk("rs_doe", dev_oe, 2'b01);
    chk("rs_line", dev_out, {J, K});
    host_in = K;
    reset = 1'b1;
    tick();
    chk("rs_doe0", dev_oe, 0);
    chk("rs_hoe0", host_oe, 0);
    chk("rs_dline", dev_out, 4'b1010);
    chk("rs_hline", host_out, J);
    chk("rs_state", st, 0);
    chk("rs_conn", conn, 0);
    chk("rs_en0", en, 0);
    reset = 1'b0;
    host_in = J;
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/usb_hub_repeater.md
# usb_hub_repeater

Parametrised packet repeater for the USB hub, sitting between the upstream (host) transceiver and `NUM_USB_DEVICES` downstream transceivers inside the hub top level. It works on sampled line states, one sample per `hi_clock` cycle. It tracks connect/enable status per downstream port and broadcasts host packets to all enabled ports. It arbitrates upstream traffic from one device at a time, and ends babbling or vanished upstream transfers with a forced EOP.

## Interface
- `NUM_USB_DEVICES`, 2 — downstream port count N (≥1). `PW = max(1, $clog2(N))`.
- `CONNECT_DEBOUNCE`, 16 — cycles of stable line state required for connect or disconnect.
- `MAX_PKT_CYCLES`, 1500 — maximum upstream packet length before babble.
- Line encoding: 2'b10 = J (idle), 2'b01 = K, 2'b00 = SE0, 2'b11 = SE1 (treated as SE0).

Ports:
- `hi_clock` in 1 — sampling clock; one line sample per cycle.
- `reset` in 1 — reset; synchronous, active-high.
- `host_line_in` in 2 — upstream line state.
- `host_line_out` out 2 — line state driven upstream.
- `host_oe` out 1 — upstream drive enable.
- `dev_line_in` in 2N — downstream line states; port k uses bits [2k+1:2k].
- `dev_line_out` out 2N — line states driven downstream.
- `dev_oe` out N — per-port downstream drive enable.
- `port_enable_req` in N — one-cycle pulse; enable the port if it is connected.
- `port_disable_req` in N — one-cycle pulse; disable the port.
- `port_status_clr` in N — one-cycle pulse; clear the sticky babble flag.
- `port_connected` out N — debounced connect status.
- `port_enabled` out N — port enabled for repeating.
- `port_babble` out N — sticky babble flag.
- `active_port` out PW — port owning the current upstream packet.
- `rpt_state` out 3 — FSM state, for debug.

## Operation
- **Reset values:** all outputs 0; `host_line_out` and `dev_line_out` = J; FSM in IDLE; all counters 0.
- **Connect tracking (per port, independent counters):**
  - J held for `CONNECT_DEBOUNCE` consecutive cycles sets `port_connected`.
  - SE0 held for `CONNECT_DEBOUNCE` consecutive cycles clears `port_connected` and `port_enabled`.
  - Any other sample resets that port's counter.
- **Enable/disable:**
  - `port_enable_req` on an unconnected port is ignored.
  - A disable request has priority over a simultaneous enable request.
  - `port_enabled` updates immediately. An in-flight downstream packet keeps using the mask captured when it started.
- **FSM states:** IDLE=0, DOWN=1, UP=2, FEOP=3.
  - **IDLE:** all `oe` = 0.
    - `host_line_in` == K → DOWN; capture `fwd_mask = port_enabled`.
    - Otherwise, if any enabled port shows K → UP with the lowest-index such port; `active_port` latched.
    - Host K and device K in the same cycle: host wins. Devices simply lose that contention; no special handling.
  - **DOWN:**
    - `dev_line_out[k]` = previous-cycle `host_line_in` for every port in `fwd_mask`, with `dev_oe = fwd_mask`.
    - First J sample after ≥1 SE0 sample is forwarded, then → IDLE on the next cycle.
  - **UP:**
    - `host_line_out` = previous-cycle sample of `dev_line_in[active_port]`, with `host_oe` = 1.
    - EOP is detected as in DOWN.
    - The packet counter increments each UP cycle and reaching `MAX_PKT_CYCLES` → FEOP with `port_babble[active]` set and `port_enabled[active]` cleared.
    - Active port disconnect or disable → FEOP without setting babble.
  - **FEOP:** drive `host_line_out` SE0 for 2 cycles then J for 1 cycle, `host_oe` = 1 throughout, then → IDLE. Input from the active port is ignored.
- **Sticky flags:** `port_babble` is cleared only by `port_status_clr` or `reset`. A set event wins over a simultaneous clear.
- **Reset mid-packet:** everything returns to reset values on the next edge; no EOP is generated.

## Timing
- Forwarding latency is exactly 1 cycle, input sample to output pin, in both directions.
- `oe` rises in the same cycle as the first forwarded K, i.e. 1 cycle after the SOP sample.
- `oe` falls the cycle after the forwarded EOP J.
- Minimum IDLE dwell between packets is 1 cycle; a K seen in that IDLE cycle starts the next packet.
- `port_connected` rises `CONNECT_DEBOUNCE` cycles after the first J sample, counting that sample as cycle 1.
- Enable/disable requests take effect on the output 1 cycle after the pulse.
- FEOP lasts 3 cycles; it is entered the cycle after the babble count is reached or the active port is lost.

## Test plan
- **Connect/enable:** port 1 held at J for 16 cycles, then `port_enable_req` = 2'b10 → `port_connected` = 2'b10 at cycle 16, `port_enabled` = 2'b10 one cycle after the pulse. Enable request to port 0 while unconnected → no change.
- **Downstream broadcast:** both ports enabled; host sends K,J,K,K,SE0,SE0,J → identical sequence on both `dev_line_out` 1 cycle later; `dev_oe` = 2'b11 for 7 cycles; then IDLE.
- **Upstream arbitration:** ports 0 and 1 both drive K in the same cycle → `active_port` = 0; port 0 stream appears on `host_line_out` with 1-cycle lag; port 1 ignored.
- **Host vs device collision:** host K and port 1 K in the same IDLE cycle → state DOWN; `host_oe` stays 0.
- **Babble:** `MAX_PKT_CYCLES` = 20; port 0 drives K/J with no EOP → after 20 UP cycles `host_line_out` = SE0,SE0,J; `port_babble` = 2'b01; `port_enabled[0]` = 0. Then `port_status_clr` = 2'b01 → `port_babble` = 0.
- **Disconnect mid-packet and reset:** active port 1 goes SE0 for 16 cycles during UP → FEOP, `port_connected[1]` = 0, no babble. Separately, `reset` asserted during DOWN → all `oe` = 0 and lines = J on the next edge.
